// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the memory-access stage and the data memory.
// The master side issues requests; the slave side answers with ready,
// and for loads with a later rvalid carrying the read doubleword.
interface mem_access_unit_if #(
  parameter int DATA_WIDTH = 64
) ();
  logic                    o_mem_req;
  logic                    o_mem_we;
  logic [DATA_WIDTH-1:0]   o_mem_addr;
  logic [DATA_WIDTH-1:0]   o_mem_wdata;
  logic [DATA_WIDTH/8-1:0] o_mem_wstrb;
  logic                    i_mem_ready;
  logic                    i_mem_rvalid;
  logic [DATA_WIDTH-1:0]   i_mem_rdata;

  modport master (
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb,
    input  i_mem_ready, i_mem_rvalid, i_mem_rdata
  );

  modport slave (
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb,
    output i_mem_ready, i_mem_rvalid, i_mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// RV64 memory-access stage. Turns the EX/MEM slot into a request/response
// transaction on the data-memory bus, lines store data up with its byte
// lanes, extracts and extends load data, and stalls the front of the
// pipeline until the access has completed. Misaligned or illegal accesses
// never reach memory; they produce a one-cycle fault pulse instead.
module mem_access_unit #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic [2:0]            i_funct3,
  input  logic [DATA_WIDTH-1:0] i_aluout,
  input  logic [DATA_WIDTH-1:0] i_wr_mem_data,
  input  logic [4:0]            i_Rd,
  mem_access_unit_if.master     mem,
  output logic                  o_stall,
  output logic                  o_load_valid,
  output logic [DATA_WIDTH-1:0] o_load_data,
  output logic [4:0]            o_load_rd,
  output logic                  o_fault
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } state_t;

  state_t                state, next_state;
  logic [2:0]            off;
  logic                  is_access;
  logic                  misaligned;
  logic                  illegal;
  logic                  legal_access;
  logic                  fault_access;
  logic                  stall_raw;
  logic [7:0]            strb_base;
  logic [DATA_WIDTH-1:0] load_shifted;
  logic [DATA_WIDTH-1:0] load_ext;

  assign off          = i_aluout[2:0];
  assign is_access    = i_valid & (i_mem_read | i_mem_write);
  assign illegal      = (i_mem_read & i_mem_write)
                      | (i_mem_read & (i_funct3 == 3'b111))
                      | (i_mem_write & i_funct3[2])
                      | misaligned;
  assign legal_access = is_access & ~illegal;
  assign fault_access = is_access & illegal;

  // Natural alignment: the low size-bits of the address must be zero
  always_comb begin
    misaligned = 1'b0;
    case (i_funct3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = |off[1:0];
      default: misaligned = |off;
    endcase
  end

  // Byte-enable pattern for the access size, shifted to its lanes
  always_comb begin
    strb_base = 8'hFF;
    case (i_funct3[1:0])
      2'b00:   strb_base = 8'h01;
      2'b01:   strb_base = 8'h03;
      2'b10:   strb_base = 8'h0F;
      default: strb_base = 8'hFF;
    endcase
  end

  // Bus outputs come straight from the stalled EX/MEM slot, so they stay
  // stable for as long as the request is held
  assign mem.o_mem_req   = (state == REQ);
  assign mem.o_mem_we    = i_mem_write;
  assign mem.o_mem_addr  = {i_aluout[DATA_WIDTH-1:3], 3'b000};
  assign mem.o_mem_wdata = i_wr_mem_data << {off, 3'b000};
  assign mem.o_mem_wstrb = strb_base << off;

  // Move the addressed bytes down to bit 0, then sign- or zero-extend
  always_comb begin
    load_shifted = mem.i_mem_rdata >> {off, 3'b000};
    load_ext     = load_shifted;
    case (i_funct3)
      3'b000:  load_ext = {{56{load_shifted[7]}},  load_shifted[7:0]};
      3'b001:  load_ext = {{48{load_shifted[15]}}, load_shifted[15:0]};
      3'b010:  load_ext = {{32{load_shifted[31]}}, load_shifted[31:0]};
      3'b100:  load_ext = {56'd0, load_shifted[7:0]};
      3'b101:  load_ext = {48'd0, load_shifted[15:0]};
      3'b110:  load_ext = {32'd0, load_shifted[31:0]};
      default: load_ext = load_shifted;
    endcase
  end

  // Access state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next state and stall; stall drops in the completion cycle so EX/MEM
  // advances on the same edge that returns the FSM to IDLE
  always_comb begin
    next_state = state;
    stall_raw  = 1'b0;
    case (state)
      IDLE: begin
        if (legal_access) begin
          next_state = REQ;
          stall_raw  = 1'b1;
        end
      end
      REQ: begin
        if (i_mem_write) begin
          stall_raw = ~mem.i_mem_ready;
          if (mem.i_mem_ready) next_state = IDLE;
        end else begin
          stall_raw = 1'b1;
          if (mem.i_mem_ready) next_state = WAIT_R;
        end
      end
      WAIT_R: begin
        stall_raw = ~mem.i_mem_rvalid;
        if (mem.i_mem_rvalid) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign o_stall = stall_raw & rst_n;

  // Registered writeback and fault pulses toward MEM/WB
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_load_valid <= 1'b0;
      o_load_data  <= '0;
      o_load_rd    <= 5'd0;
      o_fault      <= 1'b0;
    end else begin
      o_load_valid <= 1'b0;
      o_fault      <= (state == IDLE) & fault_access;
      if ((state == WAIT_R) && mem.i_mem_rvalid) begin
        o_load_valid <= 1'b1;
        o_load_data  <= load_ext;
        o_load_rd    <= i_Rd;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for the memory-access stage: stores, loads with memory
// wait states, faulty accesses, pass-through slots and reset mid-access.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic        i_mem_read;
  logic        i_mem_write;
  logic [2:0]  i_funct3;
  logic [63:0] i_aluout;
  logic [63:0] i_wr_mem_data;
  logic [4:0]  i_Rd;
  logic        o_stall;
  logic        o_load_valid;
  logic [63:0] o_load_data;
  logic [4:0]  o_load_rd;
  logic        o_fault;

  mem_access_unit_if #(.DATA_WIDTH(64)) bus ();

  mem_access_unit #(.DATA_WIDTH(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (i_valid),
    .i_mem_read   (i_mem_read),
    .i_mem_write  (i_mem_write),
    .i_funct3     (i_funct3),
    .i_aluout     (i_aluout),
    .i_wr_mem_data(i_wr_mem_data),
    .i_Rd         (i_Rd),
    .mem          (bus),
    .o_stall      (o_stall),
    .o_load_valid (o_load_valid),
    .o_load_data  (o_load_data),
    .o_load_rd    (o_load_rd),
    .o_fault      (o_fault)
  );

  int vec_count;
  int miscompares;

  int          stall_cyc;
  int          req_cyc;
  int          lv_pulses;
  int          fault_pulses;
  logic        timed_out;
  logic [7:0]  cap_strb;
  logic [63:0] cap_addr;
  logic [63:0] cap_wdata;
  logic        cap_we;

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Drives one EX/MEM slot and plays a memory that raises ready after
  // ready_wait request cycles and rvalid after rvalid_wait response cycles.
  // Called right after a rising edge; returns right after a rising edge.
  task automatic applyStimulus(input logic valid, input logic rd,
                               input logic wr, input logic [2:0] f3,
                               input logic [63:0] addr,
                               input logic [63:0] wdata,
                               input logic [63:0] rdata,
                               input logic [4:0] rdi,
                               input int ready_wait, input int rvalid_wait);
    int   req_cnt;
    int   rv_cnt;
    int   cyc;
    logic in_wait;
    logic next_wait;
    logic done;
    stall_cyc    = 0;
    req_cyc      = 0;
    lv_pulses    = 0;
    fault_pulses = 0;
    timed_out    = 1'b0;
    cap_strb     = 8'h00;
    cap_addr     = 64'd0;
    cap_wdata    = 64'd0;
    cap_we       = 1'b0;
    i_valid       = valid;
    i_mem_read    = rd;
    i_mem_write   = wr;
    i_funct3      = f3;
    i_aluout      = addr;
    i_wr_mem_data = wdata;
    i_Rd          = rdi;
    bus.i_mem_rdata = rdata;
    req_cnt = 0;
    rv_cnt  = 0;
    cyc     = 0;
    in_wait = 1'b0;
    done    = 1'b0;
    while (!done) begin
      bus.i_mem_ready  = bus.o_mem_req && (req_cnt == ready_wait);
      bus.i_mem_rvalid = in_wait && (rv_cnt == rvalid_wait);
      #1;
      next_wait = in_wait && !bus.i_mem_rvalid;
      if (bus.o_mem_req) begin
        req_cyc++;
        req_cnt++;
        cap_strb  = bus.o_mem_wstrb;
        cap_addr  = bus.o_mem_addr;
        cap_wdata = bus.o_mem_wdata;
        cap_we    = bus.o_mem_we;
        if (bus.i_mem_ready && rd) next_wait = 1'b1;
      end
      if (in_wait) rv_cnt++;
      if (o_stall) stall_cyc++;
      else         done = 1'b1;
      @(posedge clk);
      #1;
      in_wait = next_wait;
      if (o_load_valid) lv_pulses++;
      if (o_fault)      fault_pulses++;
      cyc++;
      if (cyc > 40) begin
        timed_out = 1'b1;
        done      = 1'b1;
      end
    end
    i_valid          = 1'b0;
    i_mem_read       = 1'b0;
    i_mem_write      = 1'b0;
    bus.i_mem_ready  = 1'b0;
    bus.i_mem_rvalid = 1'b0;
    @(posedge clk);
    #1;
    if (o_load_valid) lv_pulses++;
    if (o_fault)      fault_pulses++;
  endtask

  task automatic storeVec(input string name, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] data,
                          input int ready_wait, input logic [63:0] exp_addr,
                          input logic [7:0] exp_strb,
                          input logic [63:0] exp_wdata, input int exp_stall);
    logic [63:0] mask;
    applyStimulus(1'b1, 1'b0, 1'b1, f3, addr, data, 64'd0, 5'd0,
                  ready_wait, 0);
    mask = 64'd0;
    for (int i = 0; i < 8; i++)
      if (exp_strb[i]) mask[8*i +: 8] = 8'hFF;
    checkOutput({name, "_timeout"}, 64'(timed_out), 64'd0);
    checkOutput({name, "_stall"}, 64'(stall_cyc), 64'(exp_stall));
    checkOutput({name, "_req"}, 64'(req_cyc), 64'(ready_wait + 1));
    checkOutput({name, "_we"}, 64'(cap_we), 64'd1);
    checkOutput({name, "_addr"}, cap_addr, exp_addr);
    checkOutput({name, "_strb"}, 64'(cap_strb), 64'(exp_strb));
    checkOutput({name, "_wdata"}, cap_wdata & mask, exp_wdata);
    checkOutput({name, "_lv"}, 64'(lv_pulses), 64'd0);
    checkOutput({name, "_fault"}, 64'(fault_pulses), 64'd0);
  endtask

  task automatic loadVec(input string name, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] rdata,
                         input logic [4:0] rdi, input int ready_wait,
                         input int rvalid_wait, input logic [63:0] exp_addr,
                         input logic [63:0] exp_data, input int exp_stall);
    applyStimulus(1'b1, 1'b1, 1'b0, f3, addr, 64'd0, rdata, rdi,
                  ready_wait, rvalid_wait);
    checkOutput({name, "_timeout"}, 64'(timed_out), 64'd0);
    checkOutput({name, "_stall"}, 64'(stall_cyc), 64'(exp_stall));
    checkOutput({name, "_we"}, 64'(cap_we), 64'd0);
    checkOutput({name, "_addr"}, cap_addr, exp_addr);
    checkOutput({name, "_lv"}, 64'(lv_pulses), 64'd1);
    checkOutput({name, "_data"}, o_load_data, exp_data);
    checkOutput({name, "_rd"}, 64'(o_load_rd), 64'(rdi));
  endtask

  task automatic faultVec(input string name, input logic valid,
                          input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [63:0] addr, input int exp_fault);
    applyStimulus(valid, rd, wr, f3, addr, 64'h0123_4567_89AB_CDEF,
                  64'hFEDC_BA98_7654_3210, 5'd1, 0, 0);
    checkOutput({name, "_stall"}, 64'(stall_cyc), 64'd0);
    checkOutput({name, "_req"}, 64'(req_cyc), 64'd0);
    checkOutput({name, "_lv"}, 64'(lv_pulses), 64'd0);
    checkOutput({name, "_fault"}, 64'(fault_pulses), 64'(exp_fault));
  endtask

  // Directed sequence
  initial begin
    vec_count        = 0;
    miscompares      = 0;
    rst_n            = 1'b0;
    i_valid          = 1'b1;
    i_mem_read       = 1'b0;
    i_mem_write      = 1'b1;
    i_funct3         = 3'b011;
    i_aluout         = 64'h1000;
    i_wr_mem_data    = 64'd0;
    i_Rd             = 5'd0;
    bus.i_mem_ready  = 1'b0;
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata  = 64'd0;

    // A legal store is presented during reset: stall must stay forced low
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req", 64'(bus.o_mem_req), 64'd0);
    checkOutput("rst_stall", 64'(o_stall), 64'd0);
    checkOutput("rst_lv", 64'(o_load_valid), 64'd0);
    checkOutput("rst_fault", 64'(o_fault), 64'd0);
    checkOutput("rst_data", o_load_data, 64'd0);
    checkOutput("rst_rd", 64'(o_load_rd), 64'd0);
    i_valid = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk);
    #1;

    storeVec("sd", 3'b011, 64'h1000, 64'h1122_3344_5566_7788, 0,
             64'h1000, 8'hFF, 64'h1122_3344_5566_7788, 1);
    storeVec("sb", 3'b000, 64'h1005, 64'h0000_0000_0000_00AB, 0,
             64'h1000, 8'h20, 64'h0000_AB00_0000_0000, 1);
    storeVec("sh", 3'b001, 64'h100A, 64'h0000_0000_0000_BEEF, 0,
             64'h1008, 8'h0C, 64'h0000_0000_BEEF_0000, 1);
    storeVec("sw", 3'b010, 64'h1004, 64'h0000_0000_DEAD_BEEF, 3,
             64'h1000, 8'hF0, 64'hDEAD_BEEF_0000_0000, 4);
    storeVec("sb0", 3'b000, 64'h1000, 64'hFFFF_FFFF_FFFF_FF5A, 0,
             64'h1000, 8'h01, 64'h0000_0000_0000_005A, 1);

    loadVec("lh", 3'b001, 64'h2006, 64'h8001_0000_0000_0000, 5'd7, 2, 4,
            64'h2000, 64'hFFFF_FFFF_FFFF_8001, 8);
    loadVec("lwu", 3'b110, 64'h2004, 64'h8000_0000_1234_5678, 5'd9, 0, 0,
            64'h2000, 64'h0000_0000_8000_0000, 2);
    loadVec("lb", 3'b000, 64'h2003, 64'h1122_3344_8566_7788, 5'd10, 0, 1,
            64'h2000, 64'hFFFF_FFFF_FFFF_FF85, 3);
    loadVec("lbu", 3'b100, 64'h2003, 64'h1122_3344_8566_7788, 5'd11, 1, 0,
            64'h2000, 64'h0000_0000_0000_0085, 3);
    loadVec("lhu", 3'b101, 64'h2002, 64'h1122_3344_8566_7788, 5'd12, 0, 0,
            64'h2000, 64'h0000_0000_0000_8566, 2);
    loadVec("lw", 3'b010, 64'h2000, 64'h1122_3344_8566_7788, 5'd13, 0, 0,
            64'h2000, 64'hFFFF_FFFF_8566_7788, 2);
    loadVec("ld", 3'b011, 64'h2008, 64'h8877_6655_4433_2211, 5'd31, 0, 0,
            64'h2008, 64'h8877_6655_4433_2211, 2);

    faultVec("lw_mis", 1'b1, 1'b1, 1'b0, 3'b010, 64'h2002, 1);
    checkOutput("lw_mis_keep", o_load_data, 64'h8877_6655_4433_2211);
    faultVec("ld_mis", 1'b1, 1'b1, 1'b0, 3'b011, 64'h2004, 1);
    faultVec("sh_mis", 1'b1, 1'b0, 1'b1, 3'b001, 64'h1001, 1);
    faultVec("st_f3", 1'b1, 1'b0, 1'b1, 3'b100, 64'h1000, 1);
    faultVec("ld_f3", 1'b1, 1'b1, 1'b0, 3'b111, 64'h2000, 1);
    faultVec("rdwr", 1'b1, 1'b1, 1'b1, 3'b011, 64'h2000, 1);
    faultVec("novalid", 1'b0, 1'b1, 1'b0, 3'b010, 64'h2002, 0);
    faultVec("noacc", 1'b1, 1'b0, 1'b0, 3'b011, 64'h2003, 0);

    // LD reaches WAIT_R, reset for one cycle, then a late rvalid arrives
    i_valid         = 1'b1;
    i_mem_read      = 1'b1;
    i_mem_write     = 1'b0;
    i_funct3        = 3'b011;
    i_aluout        = 64'h3000;
    i_Rd            = 5'd3;
    bus.i_mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    @(posedge clk);
    #1;
    bus.i_mem_ready = 1'b1;
    #1;
    checkOutput("rstmid_req", 64'(bus.o_mem_req), 64'd1);
    @(posedge clk);
    #1;
    bus.i_mem_ready = 1'b0;
    #1;
    checkOutput("rstmid_wait_stall", 64'(o_stall), 64'd1);
    rst_n   = 1'b0;
    i_valid = 1'b0;
    #1;
    checkOutput("rstmid_stall_forced", 64'(o_stall), 64'd0);
    @(posedge clk);
    #1;
    rst_n            = 1'b1;
    bus.i_mem_rvalid = 1'b1;
    #1;
    checkOutput("rstmid_req_idle", 64'(bus.o_mem_req), 64'd0);
    checkOutput("rstmid_stall", 64'(o_stall), 64'd0);
    checkOutput("rstmid_lv", 64'(o_load_valid), 64'd0);
    checkOutput("rstmid_fault", 64'(o_fault), 64'd0);
    checkOutput("rstmid_data", o_load_data, 64'd0);
    checkOutput("rstmid_rd", 64'(o_load_rd), 64'd0);
    @(posedge clk);
    #1;
    bus.i_mem_rvalid = 1'b0;
    checkOutput("rstmid_late_lv", 64'(o_load_valid), 64'd0);
    checkOutput("rstmid_late_data", o_load_data, 64'd0);
    @(posedge clk);
    #1;
    checkOutput("rstmid_after_lv", 64'(o_load_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count,
             miscompares);
    $finish;
  end

endmodule
